// File: rtl/addsub_signed_pipe.sv
// rtl/addsub_signed_pipe.sv - pipelined signed add/subtract with saturation, valid/ready handshakes and overflow counter
module addsub_signed_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_op,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_overflow,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             ovf_clear
);

    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [STAGES-1:0] ovf_q;
    logic [STAGES-1:0] load;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic [WIDTH:0]    a_ext;
    logic [WIDTH:0]    b_ext;
    logic [WIDTH:0]    r_ext;
    logic [WIDTH-1:0]  res_d;
    logic              ovf_d;

    // Exact result at WIDTH+1 bits: overflow iff the two top bits disagree,
    // which also covers subtracting the most negative value.
    always_comb begin
        a_ext = {in_a[WIDTH-1], in_a};
        b_ext = {in_b[WIDTH-1], in_b};
        r_ext = in_op ? (a_ext - b_ext) : (a_ext + b_ext);
        ovf_d = r_ext[WIDTH] ^ r_ext[WIDTH-1];
        res_d = r_ext[WIDTH-1:0];
        if (in_sat && ovf_d) begin
            res_d = r_ext[WIDTH] ? MIN_VAL : MAX_VAL;
        end
    end

    // A stage may load if the output drains or any stage at or after it is empty.
    always_comb begin
        load = '0;
        for (int k = 0; k < STAGES; k++) begin
            load[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!valid_q[j]) begin
                    load[k] = 1'b1;
                end
            end
        end
    end

    assign in_ready = load[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            ovf_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                res_q[k] <= '0;
            end
        end else begin
            if (load[0]) begin
                valid_q[0] <= in_valid;
                res_q[0]   <= res_d;
                ovf_q[0]   <= ovf_d;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (load[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    res_q[k]   <= res_q[k-1];
                    ovf_q[k]   <= ovf_q[k-1];
                end
            end
        end
    end

    assign out_valid    = valid_q[STAGES-1];
    assign out_result   = res_q[STAGES-1];
    assign out_overflow = ovf_q[STAGES-1];

    // Clear wins over a coincident counting delivery; count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (ovf_clear) begin
            cnt_d = '0;
        end else if (out_valid && out_ready && out_overflow && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ovf_count = cnt_q;

endmodule

// File: tb/tb_addsub_signed_pipe.sv
// tb/tb_addsub_signed_pipe.sv - scoreboard bench for addsub_signed_pipe (WIDTH=32, STAGES=2, CNT_W=2)
module tb_addsub_signed_pipe;

    localparam logic [31:0] MAXV = 32'h7FFFFFFF;
    localparam logic [31:0] MINV = 32'h80000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_op;
    logic        in_sat;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic [1:0]  ovf_count;
    logic        ovf_clear;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
    } exp_t;

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;
    int   n_deliv = 0;
    int   base;

    addsub_signed_pipe #(.WIDTH(32), .STAGES(2), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_sat(in_sat),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_overflow(out_overflow),
        .ovf_count(ovf_count), .ovf_clear(ovf_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic op, input logic sat);
        exp_t   e;
        longint sa;
        longint sbv;
        longint r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        r   = op ? (sa - sbv) : (sa + sbv);
        e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.res = r[31:0];
        if (sat && e.ovf) e.res = (r > 0) ? MAXV : MINV;
        return e;
    endfunction

    // Drives at a falling edge; returns just after the accepting rising edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic op,
                         input logic sat, input logic [31:0] eres, input logic eovf);
        exp_t e;
        int   tries;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_sat = sat;
        #1;
        tries = 0;
        while (!in_ready && tries < 30) begin
            @(negedge clk);
            #1;
            tries++;
        end
        if (!in_ready) begin
            chk("issue_timeout", 64'd0, 64'd1);
        end else begin
            @(posedge clk);
            e.res = eres;
            e.ovf = eovf;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
        @(negedge clk);
        #3;
    endtask

    // Monitor: compares every delivery against the scoreboard and checks stall stability.
    initial begin : monitor
        logic        prev_stall;
        logic [31:0] prev_res;
        logic        prev_ovf;
        exp_t        e;
        prev_stall = 1'b0;
        prev_res   = '0;
        prev_ovf   = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_payload", {31'd0, out_overflow, out_result}, {31'd0, prev_ovf, prev_res});
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 64'(out_result), 64'hDEAD);
                    end else begin
                        e = sb.pop_front();
                        chk("result", 64'(out_result), 64'(e.res));
                        chk("overflow", 64'(out_overflow), 64'(e.ovf));
                        n_deliv++;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_res   = out_result;
                prev_ovf   = out_overflow;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] corners [9];
        exp_t        e;
        int          acc;
        corners = '{32'h80000000, 32'h80000001, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0,
                    32'h1, 32'h2, 32'h7FFFFFFE, 32'h7FFFFFFF};
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; in_sat = 1'b0;
        out_ready = 1'b1; ovf_clear = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_ovf_count", 64'(ovf_count), 64'd0);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_out_overflow", 64'(out_overflow), 64'd0);

        // 5-7, latency of exactly two cycles
        issue(32'd5, 32'd7, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0);
        idle();
        #1;
        chk("lat_cycle1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        #1;
        chk("lat_cycle2_valid", 64'(out_valid), 64'd1);
        chk("lat_cycle2_result", 64'(out_result), 64'hFFFFFFFE);
        drain();

        // back-to-back throughput
        base = n_deliv;
        issue(32'd10, 32'd20, 1'b0, 1'b0, 32'd30, 1'b0);
        issue(32'd10, 32'd20, 1'b1, 1'b0, 32'hFFFFFFF6, 1'b0);
        issue(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 32'd0, 1'b0);
        issue(32'd1000, 32'hFFFFFC18, 1'b1, 1'b1, 32'd2000, 1'b0);
        idle();
        @(negedge clk);
        #3;
        chk("throughput_count", 64'(n_deliv - base), 64'd4);
        drain();

        // subtraction / addition corner cases
        issue(32'd0, MINV, 1'b1, 1'b0, 32'h80000000, 1'b1);
        issue(32'd0, MINV, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1);
        issue(32'hFFFFFFFF, MINV, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b0);
        issue(MAXV, 32'd1, 1'b0, 1'b0, 32'h80000000, 1'b1);
        issue(MAXV, 32'd1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1);
        issue(MINV, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b1);
        idle();
        drain();

        // corner cross product against the wide reference model
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 9; j++) begin
                for (int m = 0; m < 4; m++) begin
                    e = model(corners[i], corners[j], m[0], m[1]);
                    issue(corners[i], corners[j], m[0], m[1], e.res, e.ovf);
                end
            end
        end
        idle();
        drain();

        // backpressure: two accepted, then in_ready drops
        out_ready = 1'b0;
        base = n_deliv;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            case (acc)
                0: begin in_a = 32'd1;  in_b = 32'd2; in_op = 1'b0; end
                default: begin in_a = 32'd10; in_b = 32'd3; in_op = 1'b1; end
            endcase
            in_sat = 1'b0;
            #1;
            if (in_ready && acc < 2) begin
                @(posedge clk);
                e.res = (acc == 0) ? 32'd3 : 32'd7;
                e.ovf = 1'b0;
                sb.push_back(e);
                acc++;
            end
        end
        #1;
        chk("bp_accepted", 64'(acc), 64'd2);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        issue(32'hFFFFFFFB, 32'hFFFFFFFA, 1'b0, 1'b0, 32'hFFFFFFF5, 1'b0);
        issue(32'd100, 32'd200, 1'b1, 1'b0, 32'hFFFFFF9C, 1'b0);
        idle();
        drain();
        chk("bp_delivered", 64'(n_deliv - base), 64'd4);

        // overflow counter (CNT_W=2)
        @(negedge clk);
        ovf_clear = 1'b1;
        @(negedge clk);
        ovf_clear = 1'b0;
        #1;
        chk("cnt_cleared", 64'(ovf_count), 64'd0);
        for (int k = 0; k < 3; k++) issue(MAXV, 32'd1, 1'b0, 1'b0, 32'h80000000, 1'b1);
        idle();
        drain();
        chk("cnt_three", 64'(ovf_count), 64'd3);
        issue(MAXV, 32'd1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1);
        idle();
        drain();
        chk("cnt_saturated", 64'(ovf_count), 64'd3);
        issue(MINV, 32'd1, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1);
        idle();
        @(negedge clk);
        ovf_clear = 1'b1;
        #1;
        chk("clr_coincide_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        ovf_clear = 1'b0;
        #1;
        chk("cnt_clear_priority", 64'(ovf_count), 64'd0);
        drain();
        issue(32'd0, MINV, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1);
        idle();
        drain();
        chk("cnt_after_clear", 64'(ovf_count), 64'd1);

        // reset with pipeline full and stalled
        out_ready = 1'b0;
        issue(32'd1, 32'd1, 1'b0, 1'b0, 32'd2, 1'b0);
        issue(MAXV, MAXV, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_ovf_count", 64'(ovf_count), 64'd0);
        out_ready = 1'b1;
        base = n_deliv;
        issue(32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0);
        idle();
        drain();
        chk("post_rst_delivered", 64'(n_deliv - base), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_signed_pipe.md
Name: addsub_signed_pipe

Overview:
- Parametrised, pipelined signed add/subtract unit. Successor to the fixed 32-bit signed subtractor.
- Adds per-operation add/sub select and optional saturation.
- Uses valid/ready handshakes on input and output, with configurable pipeline depth.
- Keeps a sticky, saturating overflow event counter for datapath health monitoring.

Parameters:
- WIDTH, 32, operand and result width in bits (two's complement), >= 2.
- STAGES, 2, pipeline register stages from input accept to output valid, >= 1.
- CNT_W, 16, width of overflow event counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  unit can accept an operation this cycle.
- in_a  in  WIDTH  signed operand A.
- in_b  in  WIDTH  signed operand B.
- in_op  in  1  0 = A+B, 1 = A-B.
- in_sat  in  1  1 = saturate result on overflow, 0 = wrap.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_result  out  WIDTH  signed result.
- out_overflow  out  1  exact result was not representable in WIDTH bits.
- ovf_count  out  CNT_W  number of delivered overflowing results, saturating.
- ovf_clear  in  1  synchronous clear of ovf_count.

Behaviour:
- Reset:
  - All stage valid bits are 0; out_valid=0, out_result=0, out_overflow=0, ovf_count=0.
  - in_ready=1 in the first cycle after reset.
  - Reset asserted mid-operation discards all in-flight operations. No stale result may appear after reset.
- Handshakes:
  - Input is accepted when in_valid && in_ready.
  - Output is delivered when out_valid && out_ready.
  - Payload and out_valid hold stable while out_valid && !out_ready.
- Pipeline advance:
  - Each stage k holds valid_k plus payload.
  - Stage k loads when it is empty or its content moves downstream in the same cycle.
  - in_ready = stage-0 load condition; this is combinational from out_ready through the chain, which is allowed.
  - Bubbles collapse: no empty stage stalls a later one.
- Latency and throughput:
  - Result is valid exactly STAGES cycles after acceptance when unstalled.
  - Throughput is 1 op/cycle with out_ready held high.
  - Capacity is exactly STAGES operations. Order is preserved, with no loss or duplication.
- Arithmetic, computed in the first stage at WIDTH+1 bits with sign extension:
  - Exact result r = A + B or A - B.
  - out_overflow = 1 iff r lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Subtraction must flag overflow correctly for B = -2^(WIDTH-1); e.g. 0 - MIN overflows. A ~B+1 negate-then-add overflow check misses this case and must not be used.
- Result selection:
  - in_sat=0: out_result = r[WIDTH-1:0] (wrap).
  - in_sat=1 and overflow: out_result = MAX if r > 0, else MIN.
  - out_overflow is reported identically in both modes.
- Overflow counter:
  - Increments by 1 on each delivered result with out_overflow=1.
  - Holds at 2^CNT_W-1 and does not wrap.
  - ovf_clear has priority: if it coincides with a counting delivery, ovf_count becomes 0 and that event is not counted.
  - ovf_clear does not affect the pipeline.
- in_op and in_sat are sampled only on acceptance and travel with the operation.

Test Plan:
- WIDTH=32, STAGES=2, sub 5-7, out_ready=1 -> out_result=-2, out_overflow=0, out_valid exactly 2 cycles after accept; back-to-back ops produce one result per cycle in order.
- Sub 0 - (-2147483648): in_sat=0 -> result 0x80000000, overflow=1; in_sat=1 -> 0x7FFFFFFF, overflow=1. Sub (-1) - (-2147483648) -> 2147483647, overflow=0.
- Add 2147483647+1: wrap -> 0x80000000, ovf=1; sat -> 0x7FFFFFFF. Add -2147483648 + -1 with sat -> 0x80000000, ovf=1. Full 9x9 corner-value cross product in both ops matches a WIDTH+1-bit reference model.
- Backpressure, STAGES=2: issue 4 ops with out_ready=0 -> in_ready drops after 2 accepted. Then release out_ready -> all 4 results delivered in order, no duplicates; payload stable while stalled.
- Counter, CNT_W=2: 3 overflowing deliveries -> ovf_count=3; a 4th -> stays 3. ovf_clear coincident with a 5th overflowing delivery -> ovf_count=0.
- Assert rst for one cycle with the pipeline full and out_ready=0 -> next cycle out_valid=0, in_ready=1, ovf_count=0; the next accepted op returns only its own result.
